huff_rx_sequencer: RTL

Sequences the receive side of the Huffman decompressor. Owns the UART receiver's byte handshake and routes each received byte to the right consumer in order: header bytes to the lookup-table builder, then a 16-bit payload length, then the compressed payload bytes to the decoder. It then waits for decode completion and aborts the frame cleanly on any UART error.

---
 rtl/huff_rx_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/huff_rx_sequencer.sv
// Receive-side sequencer for the Huffman decompressor: takes UART bytes through a
// one-entry hold register and routes them to the table builder, length register and decoder.
module huff_rx_sequencer (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  rx_data,
    input  logic        data_ready,
    input  logic        overrun_error,
    input  logic        framing_error,
    output logic        data_read,
    output logic [7:0]  tab_byte,
    output logic        tab_valid,
    input  logic        tab_ack,
    input  logic        lookupDone,
    output logic [7:0]  dec_byte,
    output logic        dec_valid,
    input  logic        dec_ack,
    input  logic        decodeDone,
    output logic        saveComp,
    output logic [15:0] remaining,
    output logic        abort,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        IDLE, TABLE, LEN_HI, LEN_LO, PAYLOAD, DRAIN, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic        hold_full_q, hold_full_d;
    logic        data_read_q, data_read_d;
    logic [15:0] remaining_q, remaining_d;
    logic        abort_q, abort_d;
    logic        frame_done_q, frame_done_d;
    logic        lookup_seen_q, lookup_seen_d;
    logic        err;
    logic        can_cap;

    assign err     = overrun_error | framing_error;
    // data_read_q blocks a second capture while the UART is still dropping data_ready
    assign can_cap = data_ready & ~hold_full_q & ~data_read_q;

    always_comb begin
        state_d       = state_q;
        hold_data_d   = hold_data_q;
        hold_full_d   = hold_full_q;
        data_read_d   = 1'b0;
        remaining_d   = remaining_q;
        abort_d       = 1'b0;
        frame_done_d  = 1'b0;
        lookup_seen_d = lookup_seen_q;
        if (err) begin
            data_read_d = data_ready & ~data_read_q;
            if (state_q != IDLE) begin
                abort_d       = 1'b1;
                hold_full_d   = 1'b0;
                remaining_d   = 16'd0;
                lookup_seen_d = 1'b0;
                state_d       = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (can_cap) begin
                        hold_data_d = rx_data;
                        hold_full_d = 1'b1;
                        data_read_d = 1'b1;
                        state_d     = TABLE;
                    end
                end
                TABLE: begin
                    if (tab_ack && hold_full_q) hold_full_d = 1'b0;
                    // a lookupDone pulse seen while a byte is held is remembered until it drains
                    if ((lookupDone || lookup_seen_q) && !hold_full_q) begin
                        lookup_seen_d = 1'b0;
                        state_d       = LEN_HI;
                    end else begin
                        if (lookupDone) lookup_seen_d = 1'b1;
                        if (can_cap) begin
                            hold_data_d = rx_data;
                            hold_full_d = 1'b1;
                            data_read_d = 1'b1;
                        end
                    end
                end
                LEN_HI: begin
                    if (can_cap) begin
                        remaining_d = {rx_data, 8'h00};
                        data_read_d = 1'b1;
                        state_d     = LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (can_cap) begin
                        remaining_d = {remaining_q[15:8], rx_data};
                        data_read_d = 1'b1;
                        state_d     = ({remaining_q[15:8], rx_data} == 16'd0) ? DRAIN : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (dec_ack && hold_full_q) begin
                        hold_full_d = 1'b0;
                        if (remaining_q != 16'd0) remaining_d = remaining_q - 16'd1;
                        if (remaining_q == 16'd1) state_d = DRAIN;
                    end else if (can_cap && remaining_q != 16'd0) begin
                        hold_data_d = rx_data;
                        hold_full_d = 1'b1;
                        data_read_d = 1'b1;
                    end
                end
                DRAIN: begin
                    if (decodeDone) begin
                        frame_done_d = 1'b1;
                        state_d      = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            hold_data_q   <= 8'h00;
            hold_full_q   <= 1'b0;
            data_read_q   <= 1'b0;
            remaining_q   <= 16'd0;
            abort_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            lookup_seen_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_data_q   <= hold_data_d;
            hold_full_q   <= hold_full_d;
            data_read_q   <= data_read_d;
            remaining_q   <= remaining_d;
            abort_q       <= abort_d;
            frame_done_q  <= frame_done_d;
            lookup_seen_q <= lookup_seen_d;
        end
    end

    assign data_read  = data_read_q;
    assign tab_byte   = hold_data_q;
    assign dec_byte   = hold_data_q;
    assign tab_valid  = (state_q == TABLE) && hold_full_q;
    assign dec_valid  = (state_q == PAYLOAD) && hold_full_q;
    assign saveComp   = (state_q == PAYLOAD);
    assign remaining  = remaining_q;
    assign abort      = abort_q;
    assign frame_done = frame_done_q;

endmodule
